// File: rtl/serial_compare_framer_if.sv
// serial_compare_framer_if
//   Parallel-side buses of the serial compare framer: the operand-pair input
//   handshake (in_valid/in_ready/in_a/in_b) and the verdict output handshake
//   (out_valid/out_ready/out_less/out_eq/out_greater/out_err).
//   slave  : the framer itself.
//   master : the surrounding system that supplies pairs and consumes verdicts.
interface serial_compare_framer_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic             out_less;
    logic             out_eq;
    logic             out_greater;
    logic             out_err;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_less, out_eq, out_greater, out_err
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_less, out_eq, out_greater, out_err
    );
endinterface

// File: rtl/serial_compare_framer.sv
// serial_compare_framer
//   Front-end/back-end controller for an MSB-first serial comparator.
//   Accepts an operand pair over a valid/ready handshake, shifts both words
//   out MSB-first one bit pair per clock, holds the comparator cleared while
//   not shifting, captures the comparator verdict on the LSB cycle and offers
//   it downstream over a valid/ready handshake.
// Ports:
//   clk, rst          rising-edge clock; synchronous active-high reset
//   bus (slave)       in_valid/in_ready/in_a/in_b and
//                     out_valid/out_ready/out_less/out_eq/out_greater/out_err
//   ser_clr           comparator clear (high whenever not shifting)
//   ser_a, ser_b      current operand bits, MSB first
//   ser_last          high during the LSB cycle
//   cmp_less/eq/greater  comparator outputs for the current bit
module serial_compare_framer #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_compare_framer_if.slave bus,
    output logic                   ser_clr,
    output logic                   ser_a,
    output logic                   ser_b,
    output logic                   ser_last,
    input  logic                   cmp_less,
    input  logic                   cmp_eq,
    input  logic                   cmp_greater
);
    // One extra bit beyond $clog2 keeps WIDTH=1 at a legal 1-bit counter.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             less_q, less_d;
    logic             eq_q, eq_d;
    logic             greater_q, greater_d;
    logic             err_q, err_d;
    logic             in_shift;
    logic             last_bit;
    logic             one_hot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            less_q    <= 1'b0;
            eq_q      <= 1'b0;
            greater_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            less_q    <= less_d;
            eq_q      <= eq_d;
            greater_q <= greater_d;
            err_q     <= err_d;
        end
    end

    assign in_shift = (state_q == SHIFT);
    assign last_bit = in_shift && (cnt_q == '0);
    assign one_hot  = ( cmp_less && !cmp_eq && !cmp_greater) ||
                      (!cmp_less &&  cmp_eq && !cmp_greater) ||
                      (!cmp_less && !cmp_eq &&  cmp_greater);

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        less_d    = less_q;
        eq_d      = eq_q;
        greater_d = greater_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sa_d    = bus.in_a;
                    sb_d    = bus.in_b;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d = sa_q << 1;
                sb_d = sb_q << 1;
                if (cnt_q == '0) begin
                    // LSB cycle: the comparator output now reflects the whole word.
                    less_d    = cmp_less;
                    eq_d      = cmp_eq;
                    greater_d = cmp_greater;
                    err_d     = !one_hot;
                    state_d   = RESULT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESULT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == RESULT);
    assign bus.out_less    = less_q;
    assign bus.out_eq      = eq_q;
    assign bus.out_greater = greater_q;
    assign bus.out_err     = err_q;

    // The comparator is cleared on every edge outside SHIFT, including the accept edge.
    assign ser_clr  = !in_shift;
    assign ser_a    = in_shift && sa_q[WIDTH-1];
    assign ser_b    = in_shift && sb_q[WIDTH-1];
    assign ser_last = last_bit;
endmodule

// File: tb/tb_serial_compare_framer.sv
module tb_serial_compare_framer;
    localparam int W = 8;

    logic clk;
    logic rst;
    logic force_bad;
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_compare_framer_if #(.WIDTH(W)) bus8 ();
    serial_compare_framer_if #(.WIDTH(1)) bus1 ();

    logic ser_clr8, ser_a8, ser_b8, ser_last8;
    logic cmp_less8, cmp_eq8, cmp_greater8;
    logic ser_clr1, ser_a1, ser_b1, ser_last1;
    logic cmp_less1, cmp_eq1, cmp_greater1;

    serial_compare_framer #(.WIDTH(W)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8),
        .ser_clr(ser_clr8), .ser_a(ser_a8), .ser_b(ser_b8), .ser_last(ser_last8),
        .cmp_less(cmp_less8), .cmp_eq(cmp_eq8), .cmp_greater(cmp_greater8)
    );

    serial_compare_framer #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .ser_clr(ser_clr1), .ser_a(ser_a1), .ser_b(ser_b1), .ser_last(ser_last1),
        .cmp_less(cmp_less1), .cmp_eq(cmp_eq1), .cmp_greater(cmp_greater1)
    );

    // Behavioural MSB-first comparator: the first differing bit decides.
    // dec: 0 = equal so far, 1 = A less, 2 = A greater.
    logic [1:0] dec_q, dec_now;
    always_comb begin
        dec_now = dec_q;
        if (dec_q == 2'd0 && ser_a8 != ser_b8) dec_now = ser_a8 ? 2'd2 : 2'd1;
    end
    always_ff @(posedge clk) begin
        if (rst || ser_clr8) dec_q <= 2'd0;
        else                 dec_q <= dec_now;
    end
    assign cmp_less8    = (dec_now == 2'd1) || (force_bad && ser_last8);
    assign cmp_eq8      = (dec_now == 2'd0) || (force_bad && ser_last8);
    assign cmp_greater8 = (dec_now == 2'd2) && !(force_bad && ser_last8);

    // One-bit words: the single bit pair decides directly.
    assign cmp_less1    = !ser_a1 && ser_b1;
    assign cmp_eq1      = (ser_a1 == ser_b1);
    assign cmp_greater1 = ser_a1 && !ser_b1;

    // Stimulus driver for the WIDTH=8 instance; records what it observes.
    // Called and returns at a falling edge.
    task automatic do_frame(input logic [W-1:0] a, input logic [W-1:0] b, input int bp,
                            output logic [W-1:0] sa, output logic [W-1:0] sb,
                            output logic [W-1:0] lastv, output logic [W-1:0] clrv,
                            output int wait_cyc, output logic ov_on_time, output logic bp_ok,
                            output logic l, output logic e, output logic g, output logic er,
                            output logic after_ok);
        logic [3:0] held;
        wait_cyc = 0; sa = '0; sb = '0; lastv = '0; clrv = '0;
        ov_on_time = 1'b0; bp_ok = 1'b1; after_ok = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.in_a      = a;
        bus8.in_b      = b;
        bus8.out_ready = (bp == 0);
        while (!bus8.in_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.in_a     = W'($urandom);
        bus8.in_b     = W'($urandom);
        for (int i = 0; i < W; i++) begin
            sa[W-1-i]    = ser_a8;
            sb[W-1-i]    = ser_b8;
            lastv[W-1-i] = ser_last8;
            clrv[W-1-i]  = ser_clr8;
            @(negedge clk);
        end
        ov_on_time = bus8.out_valid;
        for (int k = 0; k < 20 && !bus8.out_valid; k++) @(negedge clk);
        l = bus8.out_less; e = bus8.out_eq; g = bus8.out_greater; er = bus8.out_err;
        held = {l, e, g, er};
        for (int k = 0; k < bp; k++) begin
            if (!bus8.out_valid || bus8.in_ready ||
                {bus8.out_less, bus8.out_eq, bus8.out_greater, bus8.out_err} != held)
                bp_ok = 1'b0;
            @(negedge clk);
        end
        if (!bus8.out_valid ||
            {bus8.out_less, bus8.out_eq, bus8.out_greater, bus8.out_err} != held)
            bp_ok = 1'b0;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        after_ok = !bus8.out_valid && bus8.in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.in_a = '0; bus8.in_b = '0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.in_a = '0; bus1.in_b = '0;
        repeat (3) @(negedge clk);
        total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus8.in_ready); end
        total++; if (ser_clr8 !== 1'b1) begin bad++; $display("FAIL reset_ser_clr got=%b exp=1", ser_clr8); end
        total++; if ({ser_a8, ser_b8, ser_last8} !== 3'b000) begin bad++; $display("FAIL reset_ser got=%b exp=000", {ser_a8, ser_b8, ser_last8}); end
        total++; if (bus8.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus8.out_valid); end
        total++; if ({bus8.out_less, bus8.out_eq, bus8.out_greater, bus8.out_err} !== 4'b0000) begin bad++; $display("FAIL reset_out got=%b exp=0000", {bus8.out_less, bus8.out_eq, bus8.out_greater, bus8.out_err}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] sa, sb, lastv, clrv;
        int wc; logic ovt, bpo, l, e, g, er, aft;
        do_frame(8'h5A, 8'h5A, 0, sa, sb, lastv, clrv, wc, ovt, bpo, l, e, g, er, aft);
        total++; if (sa !== 8'b01011010) begin bad++; $display("FAIL dir_ser_a got=%b exp=01011010", sa); end
        total++; if (sb !== 8'h5A) begin bad++; $display("FAIL dir_ser_b got=%h exp=5a", sb); end
        total++; if (lastv !== 8'b00000001) begin bad++; $display("FAIL dir_ser_last got=%b exp=00000001", lastv); end
        total++; if (clrv !== 8'h00) begin bad++; $display("FAIL dir_ser_clr got=%b exp=00000000", clrv); end
        total++; if (ovt !== 1'b1) begin bad++; $display("FAIL dir_latency out_valid_at_T0+9 got=%b exp=1", ovt); end
        total++; if ({l, e, g, er} !== 4'b0100) begin bad++; $display("FAIL dir_verdict got=%b exp=0100", {l, e, g, er}); end
        total++; if (aft !== 1'b1) begin bad++; $display("FAIL dir_return_idle got=%b exp=1", aft); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sa, sb, lastv, clrv;
        int wc; logic ovt, bpo, l, e, g, er, aft;
        do_frame(8'h80, 8'h7F, 0, sa, sb, lastv, clrv, wc, ovt, bpo, l, e, g, er, aft);
        total++; if ({l, e, g, er} !== 4'b0010) begin bad++; $display("FAIL b2b_first got=%b exp=0010", {l, e, g, er}); end
        do_frame(8'h3C, 8'h3D, 0, sa, sb, lastv, clrv, wc, ovt, bpo, l, e, g, er, aft);
        total++; if (wc !== 0) begin bad++; $display("FAIL b2b_accept_wait got=%0d exp=0", wc); end
        total++; if (ovt !== 1'b1) begin bad++; $display("FAIL b2b_latency got=%b exp=1", ovt); end
        total++; if ({l, e, g, er} !== 4'b1000) begin bad++; $display("FAIL b2b_second got=%b exp=1000", {l, e, g, er}); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] sa, sb, lastv, clrv;
        int wc; logic ovt, bpo, l, e, g, er, aft;
        do_frame(8'h11, 8'hC3, 5, sa, sb, lastv, clrv, wc, ovt, bpo, l, e, g, er, aft);
        total++; if (bpo !== 1'b1) begin bad++; $display("FAIL bp_hold_stable got=%b exp=1", bpo); end
        total++; if ({l, e, g, er} !== 4'b1000) begin bad++; $display("FAIL bp_verdict got=%b exp=1000", {l, e, g, er}); end
        total++; if (aft !== 1'b1) begin bad++; $display("FAIL bp_single_handshake got=%b exp=1", aft); end
        @(negedge clk);
        total++; if (bus8.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_repeat got=%b exp=0", bus8.out_valid); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, sa, sb, lastv, clrv;
        int wc, bp, mode; logic ovt, bpo, l, e, g, er, aft;
        logic [3:0] exp_v;
        for (int n = 0; n < 30; n++) begin
            a = W'($urandom);
            mode = int'($urandom_range(0, 3));
            if (mode == 0)      b = a;
            else if (mode == 1) b = a ^ 8'h01;
            else                b = W'($urandom);
            bp = int'($urandom_range(0, 2));
            do_frame(a, b, bp, sa, sb, lastv, clrv, wc, ovt, bpo, l, e, g, er, aft);
            exp_v = {a < b, a == b, a > b, 1'b0};
            total++; if ({sa, sb} !== {a, b}) begin bad++; $display("FAIL rnd_serial n=%0d got=%h/%h exp=%h/%h", n, sa, sb, a, b); end
            total++; if ({l, e, g, er} !== exp_v) begin bad++; $display("FAIL rnd_verdict n=%0d a=%h b=%h got=%b exp=%b", n, a, b, {l, e, g, er}, exp_v); end
            total++; if ({ovt, bpo, aft} !== 3'b111) begin bad++; $display("FAIL rnd_handshake n=%0d got=%b exp=111", n, {ovt, bpo, aft}); end
        end
    endtask

    task automatic test_rst_mid();
        logic [W-1:0] sa, sb, lastv, clrv;
        int wc; logic ovt, bpo, l, e, g, er, aft, seen;
        bus8.in_valid = 1'b1; bus8.in_a = 8'h01; bus8.in_b = 8'h02; bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({ser_clr8, bus8.in_ready, bus8.out_valid} !== 3'b110) begin bad++; $display("FAIL rstmid_ctrl got=%b exp=110", {ser_clr8, bus8.in_ready, bus8.out_valid}); end
        total++; if ({ser_a8, ser_b8, ser_last8} !== 3'b000) begin bad++; $display("FAIL rstmid_ser got=%b exp=000", {ser_a8, ser_b8, ser_last8}); end
        seen = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            if (bus8.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_valid got=%b exp=0", seen); end
        do_frame(8'h02, 8'h01, 0, sa, sb, lastv, clrv, wc, ovt, bpo, l, e, g, er, aft);
        total++; if ({l, e, g, er} !== 4'b0010) begin bad++; $display("FAIL rstmid_new_frame got=%b exp=0010", {l, e, g, er}); end
    endtask

    task automatic test_err();
        logic [W-1:0] sa, sb, lastv, clrv;
        int wc; logic ovt, bpo, l, e, g, er, aft;
        force_bad = 1'b1;
        do_frame(8'h33, 8'h35, 0, sa, sb, lastv, clrv, wc, ovt, bpo, l, e, g, er, aft);
        force_bad = 1'b0;
        total++; if ({l, e, g, er} !== 4'b1101) begin bad++; $display("FAIL err_flag got=%b exp=1101", {l, e, g, er}); end
        do_frame(8'h35, 8'h33, 0, sa, sb, lastv, clrv, wc, ovt, bpo, l, e, g, er, aft);
        total++; if ({l, e, g, er} !== 4'b0010) begin bad++; $display("FAIL err_clears got=%b exp=0010", {l, e, g, er}); end
    endtask

    task automatic test_width1();
        logic [1:0] pairs [2];
        logic [3:0] exp_v;
        int wc;
        pairs[0] = 2'b10;
        pairs[1] = 2'b00;
        for (int n = 0; n < 2; n++) begin
            bus1.in_valid = 1'b1; bus1.in_a = pairs[n][1]; bus1.in_b = pairs[n][0]; bus1.out_ready = 1'b1;
            wc = 0;
            while (!bus1.in_ready && wc < 20) begin @(negedge clk); wc++; end
            @(negedge clk);
            bus1.in_valid = 1'b0;
            total++; if ({ser_last1, ser_a1, ser_b1, ser_clr1} !== {1'b1, pairs[n], 1'b0}) begin bad++; $display("FAIL w1_shift n=%0d got=%b exp=%b", n, {ser_last1, ser_a1, ser_b1, ser_clr1}, {1'b1, pairs[n], 1'b0}); end
            @(negedge clk);
            exp_v = {pairs[n][1] < pairs[n][0], pairs[n][1] == pairs[n][0], pairs[n][1] > pairs[n][0], 1'b0};
            total++; if (bus1.out_valid !== 1'b1) begin bad++; $display("FAIL w1_valid n=%0d got=%b exp=1", n, bus1.out_valid); end
            total++; if ({bus1.out_less, bus1.out_eq, bus1.out_greater, bus1.out_err} !== exp_v) begin bad++; $display("FAIL w1_verdict n=%0d got=%b exp=%b", n, {bus1.out_less, bus1.out_eq, bus1.out_greater, bus1.out_err}, exp_v); end
            @(negedge clk);
            total++; if ({bus1.out_valid, bus1.in_ready} !== 2'b01) begin bad++; $display("FAIL w1_idle n=%0d got=%b exp=01", n, {bus1.out_valid, bus1.in_ready}); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        force_bad = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_rst_mid();
        test_err();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_compare_framer.md
Name: serial_compare_framer

Overview:
Front-end/back-end controller for the MSB-first serial comparator. Accepts a pair of parallel WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit pair per clock, on ser_a/ser_b. Generates the comparator's frame clear and captures the comparator's less/eq/greater outputs on the final bit. Presents the registered verdict downstream over a valid/ready handshake.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  word pair available.
in_ready  output  1  block can accept a pair; high only in IDLE.
in_a  input  WIDTH  operand A, sampled on accept.
in_b  input  WIDTH  operand B, sampled on accept.
ser_clr  output  1  comparator clear; integrator ORs it with rst into the comparator's rst.
ser_a  output  1  current bit of A, MSB first.
ser_b  output  1  current bit of B, MSB first.
ser_last  output  1  high during the LSB cycle of the frame.
cmp_less  input  1  comparator a_less_b; combinational on current bit.
cmp_eq  input  1  comparator a_eq_b.
cmp_greater  input  1  comparator a_greater_b.
out_valid  output  1  verdict available.
out_ready  input  1  downstream accepts verdict.
out_less  output  1  captured A < B.
out_eq  output  1  captured A == B.
out_greater  output  1  captured A > B.
out_err  output  1  captured cmp_* was not exactly one-hot.

Behaviour:
- Reset: state IDLE; shift regs, bit counter, out_less/out_eq/out_greater/out_err cleared to 0; out_valid 0; ser_a/ser_b/ser_last 0; ser_clr 1.
- States: IDLE, SHIFT, RESULT. in_ready = (state == IDLE). ser_clr = (state != SHIFT). ser_a/ser_b/ser_last are 0 outside SHIFT.
- IDLE: on in_valid && in_ready at edge T0, latch in_a/in_b into shift regs, load counter = WIDTH-1, go to SHIFT. ser_clr is high at T0, so the comparator is cleared on that same edge.
- SHIFT, cycles T0+1 .. T0+WIDTH:
  - ser_a/ser_b = shift-reg MSB.
  - Each edge: shift left by 1, decrement the counter.
  - ser_last = (counter == 0).
  - On the ser_last edge, register cmp_less/cmp_eq/cmp_greater into out_*. Set out_err = !(exactly one of the three is high). Go to RESULT.
- RESULT: out_valid = 1 from cycle T0+WIDTH+1. out_* are held stable while out_valid && !out_ready. On out_valid && out_ready, go to IDLE; in_ready is high the following cycle. Minimum period is WIDTH+2 cycles per pair.
- Latency: accept edge to out_valid = WIDTH+1 cycles.
- Counter width is $clog2(WIDTH)+1 bits, so there is no wrap for any legal WIDTH. WIDTH=1: exactly one SHIFT cycle, with ser_last high in it.
- in_valid outside IDLE is ignored; no overlap or queuing. in_a/in_b changes after accept have no effect.
- out_ready while out_valid is low is ignored.
- rst asserted in any state, including mid-SHIFT or RESULT with out_valid high: next cycle all reset values apply. The in-flight pair and its verdict are discarded, and no out_valid pulse is produced.
- out_* keep the last verdict in IDLE/SHIFT; consumers qualify them with out_valid.

Test Plan:
- WIDTH=8, in_a=0x5A, in_b=0x5A, out_ready=1 -> ser_a sequence 0,1,0,1,1,0,1,0 over 8 cycles; ser_last in the 8th; out_valid at T0+9 with out_eq=1, out_less=0, out_greater=0, out_err=0.
- in_a=0x80, in_b=0x7F -> out_greater=1. in_a=0x3C, in_b=0x3D -> out_less=1, with the decision made on the LSB. Run back-to-back; second accept lands on the cycle after the first out handshake.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_* stable, in_ready=0 throughout; release -> single handshake, then IDLE.
- rst pulsed 1 cycle at the 4th SHIFT cycle of 0x01 vs 0x02 -> out_valid never asserts; ser_clr=1 and in_ready=1 after reset; a new 0x02 vs 0x01 frame yields out_greater=1.
- Stub comparator forcing cmp_less=cmp_eq=1 at the LSB -> out_err=1. WIDTH=1 build: in_a=1, in_b=0 -> one SHIFT cycle with ser_last=1; out_greater=1 at T0+2.
